// File: rtl/sad_pkg.sv
// Shared widths and result record for the SAD1..SAD4 pipeline stages.
package sad_pkg;

  localparam int unsigned SAD_IDX_W  = 16;
  localparam int unsigned SAD_PART_W = 14;
  localparam int unsigned SAD_SUM_W  = 16;

  typedef struct packed {
    logic [SAD_IDX_W-1:0] index;
    logic [SAD_SUM_W-1:0] sad;
  } sad_result_t;

endpackage

// File: rtl/sad4_adder.sv
// SAD4 stage A: registered sum of the four partial SADs, with valid/index/trigger carried alongside.
module sad4_adder
  import sad_pkg::*;
#(
  parameter int unsigned IDX_W  = SAD_IDX_W,
  parameter int unsigned PART_W = SAD_PART_W,
  parameter int unsigned SUM_W  = SAD_SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cand_valid,
  input  logic [IDX_W-1:0]  cand_index,
  input  logic              cand_trigger,
  input  logic [PART_W-1:0] cand_part1,
  input  logic [PART_W-1:0] cand_part2,
  input  logic [PART_W-1:0] cand_part3,
  input  logic [PART_W-1:0] cand_part4,
  output logic              sum_valid,
  output logic [IDX_W-1:0]  sum_index,
  output logic              sum_trigger,
  output logic [SUM_W-1:0]  sum_total
);

  logic [SUM_W-1:0] part_sum;

  // Each partial is widened before adding so the carry out of PART_W bits is kept.
  always_comb begin
    part_sum = SUM_W'(cand_part1) + SUM_W'(cand_part2)
             + SUM_W'(cand_part3) + SUM_W'(cand_part4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_valid   <= 1'b0;
      sum_index   <= '0;
      sum_trigger <= 1'b0;
      sum_total   <= '0;
    end else begin
      sum_valid <= cand_valid;
      if (cand_valid) begin
        sum_index   <= cand_index;
        sum_trigger <= cand_trigger;
        sum_total   <= part_sum;
      end
    end
  end

endmodule

// File: rtl/sad4_min_tracker.sv
// Final SAD stage: sums partials, tracks the minimum over a search, emits it on a valid/ready port.
// Optional res_hit output (res_sad < THRESH) is built when SAD4_THRESHOLD_EN is defined.
module sad4_min_tracker
  import sad_pkg::*;
#(
  parameter int unsigned IDX_W  = SAD_IDX_W,
  parameter int unsigned PART_W = SAD_PART_W,
  parameter int unsigned SUM_W  = SAD_SUM_W,
  parameter int unsigned THRESH = 16'd256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SAD4_Valid,
  input  logic [IDX_W-1:0]  SAD4_Index,
  input  logic              SAD4_TriggerBoss,
  input  logic [PART_W-1:0] SAD4_input1,
  input  logic [PART_W-1:0] SAD4_input2,
  input  logic [PART_W-1:0] SAD4_input3,
  input  logic [PART_W-1:0] SAD4_input4,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_index,
  output logic [SUM_W-1:0]  res_sad,
  output logic              res_overrun
`ifdef SAD4_THRESHOLD_EN
  ,
  output logic              res_hit
`endif
);

  if (SUM_W < PART_W + 2) begin : g_bad_sum_w
    $error("sad4_min_tracker: SUM_W must be at least PART_W+2");
  end
  if (longint'(THRESH) > (longint'(1) << SUM_W)) begin : g_bad_thresh
    $error("sad4_min_tracker: THRESH exceeds the SUM_W range");
  end

  logic             a_valid;
  logic [IDX_W-1:0] a_index;
  logic             a_trigger;
  logic [SUM_W-1:0] a_sum;

  logic             best_valid;
  logic [SUM_W-1:0] best_sad;
  logic [IDX_W-1:0] best_index;

  logic             take_new;
  logic [SUM_W-1:0] cand_sad;
  logic [IDX_W-1:0] cand_index;
  logic             result_load;
  logic             stall;

  sad4_adder #(
    .IDX_W  (IDX_W),
    .PART_W (PART_W),
    .SUM_W  (SUM_W)
  ) u_adder (
    .clk          (clk),
    .rst_n        (rst_n),
    .cand_valid   (SAD4_Valid),
    .cand_index   (SAD4_Index),
    .cand_trigger (SAD4_TriggerBoss),
    .cand_part1   (SAD4_input1),
    .cand_part2   (SAD4_input2),
    .cand_part3   (SAD4_input3),
    .cand_part4   (SAD4_input4),
    .sum_valid    (a_valid),
    .sum_index    (a_index),
    .sum_trigger  (a_trigger),
    .sum_total    (a_sum)
  );

  // Minimum including the stage-A candidate; strict compare keeps the earlier index on ties.
  always_comb begin
    take_new    = !best_valid || (a_sum < best_sad);
    cand_sad    = take_new ? a_sum   : best_sad;
    cand_index  = take_new ? a_index : best_index;
    result_load = a_valid && a_trigger;
    stall       = res_valid && !res_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_valid <= 1'b0;
      best_sad   <= '0;
      best_index <= '0;
    end else if (a_valid) begin
      if (a_trigger) begin
        best_valid <= 1'b0;
      end else begin
        best_valid <= 1'b1;
        best_sad   <= cand_sad;
        best_index <= cand_index;
      end
    end
  end

`ifdef SAD4_THRESHOLD_EN
  localparam logic [SUM_W:0] THRESH_EXT = (SUM_W+1)'(THRESH);
`endif

  // A result finishing while the previous one is stalled is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_index   <= '0;
      res_sad     <= '0;
      res_overrun <= 1'b0;
`ifdef SAD4_THRESHOLD_EN
      res_hit     <= 1'b0;
`endif
    end else if (result_load && stall) begin
      res_overrun <= 1'b1;
    end else if (result_load) begin
      res_valid <= 1'b1;
      res_index <= cand_index;
      res_sad   <= cand_sad;
`ifdef SAD4_THRESHOLD_EN
      res_hit   <= ({1'b0, cand_sad} < THRESH_EXT);
`endif
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sad4_min_tracker.sv
// Scoreboard bench for sad4_min_tracker: directed searches plus randomized candidate streams.
module tb_sad4_min_tracker;
  import sad_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  SAD4_Valid;
  logic [SAD_IDX_W-1:0]  SAD4_Index;
  logic                  SAD4_TriggerBoss;
  logic [SAD_PART_W-1:0] SAD4_input1, SAD4_input2, SAD4_input3, SAD4_input4;
  logic                  res_valid;
  logic                  res_ready;
  logic [SAD_IDX_W-1:0]  res_index;
  logic [SAD_SUM_W-1:0]  res_sad;
  logic                  res_overrun;
`ifdef SAD4_THRESHOLD_EN
  logic                  res_hit;
`endif

  always #5 clk = ~clk;

  sad4_min_tracker #(
    .IDX_W  (SAD_IDX_W),
    .PART_W (SAD_PART_W),
    .SUM_W  (SAD_SUM_W),
    .THRESH (256)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .SAD4_Valid       (SAD4_Valid),
    .SAD4_Index       (SAD4_Index),
    .SAD4_TriggerBoss (SAD4_TriggerBoss),
    .SAD4_input1      (SAD4_input1),
    .SAD4_input2      (SAD4_input2),
    .SAD4_input3      (SAD4_input3),
    .SAD4_input4      (SAD4_input4),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_index        (res_index),
    .res_sad          (res_sad),
    .res_overrun      (res_overrun)
`ifdef SAD4_THRESHOLD_EN
    ,
    .res_hit          (res_hit)
`endif
  );

  typedef struct {
    int unsigned idx;
    int unsigned sum;
  } cand_t;

  cand_t       cands[$];
  sad_result_t exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: at the trigger, the search result is the lowest total, earliest index on ties.
  task automatic model_add(input int unsigned idx, input int unsigned sum, input bit trig,
                           input bit dropped);
    cand_t best;
    cands.push_back('{idx, sum});
    if (trig) begin
      best = cands[0];
      foreach (cands[i]) if (cands[i].sum < best.sum) best = cands[i];
      if (!dropped) exp_q.push_back('{index: best.idx[SAD_IDX_W-1:0], sad: best.sum[SAD_SUM_W-1:0]});
      cands.delete();
    end
  endtask

  task automatic send(input int unsigned idx, input int unsigned p1, input int unsigned p2,
                      input int unsigned p3, input int unsigned p4, input bit trig,
                      input bit dropped = 1'b0);
    @(posedge clk); #1;
    SAD4_Valid       = 1'b1;
    SAD4_Index       = idx[SAD_IDX_W-1:0];
    SAD4_TriggerBoss = trig;
    SAD4_input1      = p1[SAD_PART_W-1:0];
    SAD4_input2      = p2[SAD_PART_W-1:0];
    SAD4_input3      = p3[SAD_PART_W-1:0];
    SAD4_input4      = p4[SAD_PART_W-1:0];
    model_add(idx, p1 + p2 + p3 + p4, trig, dropped);
  endtask

  task automatic send_sum(input int unsigned idx, input int unsigned each, input bit trig,
                          input bit dropped = 1'b0);
    send(idx, each, each, each, each, trig, dropped);
  endtask

  // Bubbles carry random junk, including TriggerBoss, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      SAD4_Valid       = 1'b0;
      SAD4_Index       = SAD_IDX_W'($urandom);
      SAD4_TriggerBoss = 1'($urandom);
      SAD4_input1      = SAD_PART_W'($urandom);
      SAD4_input2      = SAD_PART_W'($urandom);
      SAD4_input3      = SAD_PART_W'($urandom);
      SAD4_input4      = SAD_PART_W'($urandom);
    end
  endtask

  task automatic drain(input string name);
    int budget = 60;
    idle(1);
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(2);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_index"}, res_index, 0);
    check({tag, "_sad"}, res_sad, 0);
    check({tag, "_overrun"}, res_overrun, 0);
`ifdef SAD4_THRESHOLD_EN
    check({tag, "_hit"}, res_hit, 0);
`endif
  endtask

  // Monitor: a negedge with valid&ready means a transfer on the next rising edge.
  initial begin
    sad_result_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got idx %0d sad %0d, required no result (t=%0t)",
                   res_index, res_sad, $time);
        end else begin
          e = exp_q.pop_front();
          check("res_index", res_index, e.index);
          check("res_sad", res_sad, e.sad);
`ifdef SAD4_THRESHOLD_EN
          check("res_hit", res_hit, (e.sad < 256) ? 1 : 0);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mode, p[4];
    rst_n = 1'b0;
    res_ready = 1'b1;
    SAD4_Valid = 1'b0;
    SAD4_Index = '0;
    SAD4_TriggerBoss = 1'b0;
    SAD4_input1 = '0; SAD4_input2 = '0; SAD4_input3 = '0; SAD4_input4 = '0;

    // Reset with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      SAD4_Valid       = 1'($urandom);
      SAD4_TriggerBoss = 1'($urandom);
      SAD4_Index       = SAD_IDX_W'($urandom);
      SAD4_input1      = SAD_PART_W'($urandom);
    end
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    SAD4_Valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Basic search with latency check.
    send_sum(0, 100, 1'b0);
    send_sum(1, 50, 1'b0);
    send_sum(2, 60, 1'b0);
    send_sum(3, 10, 1'b1);
    idle(1);
    @(negedge clk);
    check("latency_after_e0", res_valid, 0);
    idle(1);
    @(negedge clk);
    check("latency_after_e1", res_valid, 1);
    drain("drain_basic");

    // Tie (earlier index wins) and maximum sums.
    send_sum(5, 200, 1'b0);
    send(6, 100, 300, 150, 250, 1'b0);
    send_sum(7, 16383, 1'b1);
    send_sum(8, 16383, 1'b1);
    drain("drain_tie_max");

    // Back-to-back searches and bubbles.
    send_sum(1, 5, 1'b1);
    send_sum(2, 100, 1'b1);
    send_sum(3, 125, 1'b0);
    idle(1);
    send(4, 100, 150, 100, 100, 1'b0);
    idle(2);
    send(5, 120, 120, 120, 110, 1'b1);
    drain("drain_b2b");

    // Randomized stream with res_ready held high.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        mode = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++) begin
          case (mode)
            0:       p[k] = 16383;
            1:       p[k] = 10 * $urandom_range(0, 3);
            default: p[k] = $urandom_range(0, 16383);
          endcase
        end
        send($urandom, p[0], p[1], p[2], p[3], ($urandom_range(0, 4) == 0));
      end
    end
    send($urandom, $urandom_range(0, 16383), 7, 7, 7, 1'b1);
    drain("drain_random");

    // Backpressure: first result held, second dropped, third loads on the transfer edge.
    @(posedge clk); #1;
    res_ready = 1'b0;
    send_sum(1, 5, 1'b1);
    idle(4);
    send(9, 10, 10, 5, 5, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_index", res_index, 1);
      check("hold_sad", res_sad, 20);
    end
    check("overrun_set", res_overrun, 1);
    send(11, 5, 5, 5, 10, 1'b1);
    @(posedge clk); #1;
    SAD4_Valid = 1'b0;
    res_ready = 1'b1;
    drain("drain_backpressure");
    check("overrun_sticky", res_overrun, 1);

    // Reset mid-search, then fresh searches around the threshold.
    send_sum(20, 1, 1'b0);
    send_sum(21, 2, 1'b0);
    #2;
    rst_n = 1'b0;
    SAD4_Valid = 1'b0;
    cands.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_sum(30, 75, 1'b0);
    send_sum(31, 50, 1'b0);
    send_sum(32, 90, 1'b1);
    send_sum(40, 75, 1'b1);
    drain("drain_threshold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
